// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-bus signals for mem_port_arbiter.
// master: the arbiter itself; slave: the requesters plus the memory bus it drives.
interface mem_port_arbiter_if;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic [31:0] fetch_rdata;
    logic        fetch_done;
    logic        data_req;
    logic        data_we;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_byteen;
    logic [31:0] data_rdata;
    logic        data_done;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        busy;
    logic        error;

    modport master (
        input  fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
               data_byteen, mem_readdata, mem_waitrequest,
        output fetch_rdata, fetch_done, data_rdata, data_done, mem_address,
               mem_read, mem_write, mem_writedata, mem_byteenable, busy, error
    );

    modport slave (
        output fetch_req, fetch_addr, data_req, data_we, data_addr, data_wdata,
               data_byteen, mem_readdata, mem_waitrequest,
        input  fetch_rdata, fetch_done, data_rdata, data_done, mem_address,
               mem_read, mem_write, mem_writedata, mem_byteenable, busy, error
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between the fetch port and the data port, round-robin on contention.
// Optional bus wait-state watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_port_arbiter #(
    parameter bit          FETCH_FIRST    = 1'b0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               reset,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUS_FETCH = 2'd1,
        ST_BUS_DATA  = 2'd2,
        ST_RESP      = 2'd3
    } state_t;

    state_t      state_r, next_state_s;
    logic        prio_fetch_r, prio_fetch_s;
    logic [31:0] mem_address_r, mem_address_s;
    logic        mem_read_r, mem_read_s;
    logic        mem_write_r, mem_write_s;
    logic [31:0] mem_writedata_r, mem_writedata_s;
    logic [3:0]  mem_byteenable_r, mem_byteenable_s;
    logic [31:0] fetch_rdata_r, fetch_rdata_s;
    logic [31:0] data_rdata_r, data_rdata_s;
    logic        fetch_done_r, fetch_done_s;
    logic        data_done_r, data_done_s;
    logic        busy_r, busy_s;
    logic        error_r, error_s;

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST_C = 16'(TIMEOUT_CYCLES - 32'd1);
    logic [15:0] tmo_cnt_r, tmo_cnt_s;
`endif

    if ((TIMEOUT_CYCLES < 32'd1) || (TIMEOUT_CYCLES > 32'd65535)) begin : g_bad_timeout
        $error("mem_port_arbiter: TIMEOUT_CYCLES must be within 1..65535");
    end

    // The bus is word addressed; the byte offset is carried by the byte enables.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Next-state, arbitration and next values of every registered output.
    always_comb begin
        next_state_s     = state_r;
        prio_fetch_s     = prio_fetch_r;
        mem_address_s    = mem_address_r;
        mem_read_s       = mem_read_r;
        mem_write_s      = mem_write_r;
        mem_writedata_s  = mem_writedata_r;
        mem_byteenable_s = mem_byteenable_r;
        fetch_rdata_s    = fetch_rdata_r;
        data_rdata_s     = data_rdata_r;
        fetch_done_s     = 1'b0;
        data_done_s      = 1'b0;
        error_s          = error_r;
`ifdef MEM_TIMEOUT_EN
        tmo_cnt_s        = tmo_cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
`ifdef MEM_TIMEOUT_EN
                tmo_cnt_s = 16'd0;
`endif
                if (bus.fetch_req && (!bus.data_req || prio_fetch_r)) begin
                    next_state_s     = ST_BUS_FETCH;
                    mem_address_s    = word_align(bus.fetch_addr);
                    mem_read_s       = 1'b1;
                    mem_write_s      = 1'b0;
                    mem_writedata_s  = 32'h0000_0000;
                    mem_byteenable_s = 4'b1111;
                    prio_fetch_s     = bus.data_req ? 1'b0 : prio_fetch_r;
                end else if (bus.data_req) begin
                    next_state_s     = ST_BUS_DATA;
                    mem_address_s    = word_align(bus.data_addr);
                    mem_read_s       = ~bus.data_we;
                    mem_write_s      = bus.data_we;
                    mem_writedata_s  = bus.data_wdata;
                    mem_byteenable_s = bus.data_byteen;
                    prio_fetch_s     = bus.fetch_req ? 1'b1 : prio_fetch_r;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUS_FETCH, ST_BUS_DATA: begin
                if (!bus.mem_waitrequest) begin
                    next_state_s = ST_RESP;
                    mem_read_s   = 1'b0;
                    mem_write_s  = 1'b0;
                    if (state_r == ST_BUS_FETCH) begin
                        fetch_rdata_s = bus.mem_readdata;
                        fetch_done_s  = 1'b1;
                    end else begin
                        data_done_s  = 1'b1;
                        data_rdata_s = mem_read_r ? bus.mem_readdata : data_rdata_r;
                    end
`ifdef MEM_TIMEOUT_EN
                end else if (tmo_cnt_r == TMO_LAST_C) begin
                    // Abandon the stalled cycle but still hand the requester a done pulse.
                    next_state_s = ST_RESP;
                    mem_read_s   = 1'b0;
                    mem_write_s  = 1'b0;
                    error_s      = 1'b1;
                    if (state_r == ST_BUS_FETCH) begin
                        fetch_rdata_s = 32'h0000_0000;
                        fetch_done_s  = 1'b1;
                    end else begin
                        data_done_s  = 1'b1;
                        data_rdata_s = mem_read_r ? 32'h0000_0000 : data_rdata_r;
                    end
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 16'd1;
                end
`else
                end else begin
                    next_state_s = state_r;
                end
`endif
            end
            ST_RESP: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
        busy_s = (next_state_s != ST_IDLE);
    end

    // State and output registers; reset abandons any bus cycle at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r          <= ST_IDLE;
            prio_fetch_r     <= FETCH_FIRST;
            mem_address_r    <= 32'h0000_0000;
            mem_read_r       <= 1'b0;
            mem_write_r      <= 1'b0;
            mem_writedata_r  <= 32'h0000_0000;
            mem_byteenable_r <= 4'b0000;
            fetch_rdata_r    <= 32'h0000_0000;
            data_rdata_r     <= 32'h0000_0000;
            fetch_done_r     <= 1'b0;
            data_done_r      <= 1'b0;
            busy_r           <= 1'b0;
            error_r          <= 1'b0;
        end else begin
            state_r          <= next_state_s;
            prio_fetch_r     <= prio_fetch_s;
            mem_address_r    <= mem_address_s;
            mem_read_r       <= mem_read_s;
            mem_write_r      <= mem_write_s;
            mem_writedata_r  <= mem_writedata_s;
            mem_byteenable_r <= mem_byteenable_s;
            fetch_rdata_r    <= fetch_rdata_s;
            data_rdata_r     <= data_rdata_s;
            fetch_done_r     <= fetch_done_s;
            data_done_r      <= data_done_s;
            busy_r           <= busy_s;
            error_r          <= error_s;
        end
    end

`ifdef MEM_TIMEOUT_EN
    // Wait-state counter for the watchdog.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_r <= 16'd0;
        end else begin
            tmo_cnt_r <= tmo_cnt_s;
        end
    end
`endif

    assign bus.mem_address    = mem_address_r;
    assign bus.mem_read       = mem_read_r;
    assign bus.mem_write      = mem_write_r;
    assign bus.mem_writedata  = mem_writedata_r;
    assign bus.mem_byteenable = mem_byteenable_r;
    assign bus.fetch_rdata    = fetch_rdata_r;
    assign bus.data_rdata     = data_rdata_r;
    assign bus.fetch_done     = fetch_done_r;
    assign bus.data_done      = data_done_r;
    assign bus.busy           = busy_r;
    assign bus.error          = error_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (FETCH_FIRST=0, TIMEOUT_CYCLES=4).
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] rd_v;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .FETCH_FIRST    (1'b0),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset               = 1'b1;
        bus.fetch_req       = 1'b0;
        bus.fetch_addr      = 32'h0;
        bus.data_req        = 1'b0;
        bus.data_we         = 1'b0;
        bus.data_addr       = 32'h0;
        bus.data_wdata      = 32'h0;
        bus.data_byteen     = 4'h0;
        bus.mem_readdata    = 32'h0;
        bus.mem_waitrequest = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_rd",    32'(bus.mem_read), 32'd0);
        chk("rst_wr",    32'(bus.mem_write), 32'd0);
        chk("rst_addr",  bus.mem_address, 32'h0);
        chk("rst_be",    32'(bus.mem_byteenable), 32'h0);
        chk("rst_done",  32'({bus.fetch_done, bus.data_done}), 32'd0);
        chk("rst_frd",   bus.fetch_rdata, 32'h0);
        chk("rst_drd",   bus.data_rdata, 32'h0);
        chk("rst_err",   32'(bus.error), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Fetch read, zero wait states
        bus.fetch_req    = 1'b1;
        bus.fetch_addr   = 32'h0040_0006;
        bus.mem_readdata = 32'h8C22_0004;
        tick();
        chk("f1_rd",    32'(bus.mem_read), 32'd1);
        chk("f1_wr",    32'(bus.mem_write), 32'd0);
        chk("f1_addr",  bus.mem_address, 32'h0040_0004);
        chk("f1_be",    32'(bus.mem_byteenable), 32'hF);
        chk("f1_busy",  32'(bus.busy), 32'd1);
        chk("f1_nodone", 32'(bus.fetch_done), 32'd0);
        tick();
        chk("f1_done",  32'(bus.fetch_done), 32'd1);
        chk("f1_ddone", 32'(bus.data_done), 32'd0);
        chk("f1_rdoff", 32'(bus.mem_read), 32'd0);
        chk("f1_rdata", bus.fetch_rdata, 32'h8C22_0004);
        bus.fetch_req = 1'b0;
        tick();
        chk("f1_pulse", 32'(bus.fetch_done), 32'd0);
        chk("f1_idle",  32'(bus.busy), 32'd0);

        // Data write with three wait states; inputs change mid-transaction
        bus.data_req        = 1'b1;
        bus.data_we         = 1'b1;
        bus.data_addr       = 32'h0000_0010;
        bus.data_wdata      = 32'hDEAD_BEEF;
        bus.data_byteen     = 4'b0011;
        bus.mem_waitrequest = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("w_wr",    32'(bus.mem_write), 32'd1);
            chk("w_rd",    32'(bus.mem_read), 32'd0);
            chk("w_addr",  bus.mem_address, 32'h0000_0010);
            chk("w_data",  bus.mem_writedata, 32'hDEAD_BEEF);
            chk("w_be",    32'(bus.mem_byteenable), 32'h3);
            chk("w_nodone", 32'(bus.data_done), 32'd0);
            if (i == 0) begin
                bus.data_wdata  = 32'h0;
                bus.data_addr   = 32'h0000_0020;
                bus.data_byteen = 4'hF;
            end
            if (i == 3) begin
                bus.mem_waitrequest = 1'b0;
            end
        end
        tick();
        chk("w_done",  32'(bus.data_done), 32'd1);
        chk("w_wroff", 32'(bus.mem_write), 32'd0);
        chk("w_drd",   bus.data_rdata, 32'h0);
        bus.data_req = 1'b0;
        bus.data_we  = 1'b0;
        tick();
        chk("w_pulse", 32'(bus.data_done), 32'd0);
        chk("w_idle",  32'(bus.busy), 32'd0);

        // Simultaneous requests held across grants: data, fetch, data
        bus.fetch_req   = 1'b1;
        bus.fetch_addr  = 32'h0000_0100;
        bus.data_req    = 1'b1;
        bus.data_we     = 1'b0;
        bus.data_addr   = 32'h0000_0200;
        bus.data_byteen = 4'hF;
        for (int g = 0; g < 3; g++) begin
            rd_v = 32'h1111_1111 * 32'(g + 1);
            bus.mem_readdata = rd_v;
            tick();
            chk("rr_rd",   32'(bus.mem_read), 32'd1);
            chk("rr_wr",   32'(bus.mem_write), 32'd0);
            chk("rr_addr", bus.mem_address, (g == 1) ? 32'h0000_0100 : 32'h0000_0200);
            chk("rr_busy", 32'(bus.busy), 32'd1);
            tick();
            chk("rr_ddone", 32'(bus.data_done), (g == 1) ? 32'd0 : 32'd1);
            chk("rr_fdone", 32'(bus.fetch_done), (g == 1) ? 32'd1 : 32'd0);
            chk("rr_rdoff", 32'(bus.mem_read), 32'd0);
            chk("rr_rbusy", 32'(bus.busy), 32'd1);
            if (g == 1) begin
                chk("rr_frd", bus.fetch_rdata, rd_v);
            end else begin
                chk("rr_drd", bus.data_rdata, rd_v);
            end
            if (g == 2) begin
                bus.fetch_req = 1'b0;
                bus.data_req  = 1'b0;
            end
            tick();
            chk("rr_idle", 32'(bus.busy), 32'd0);
        end
        chk("rr_frd_hold", bus.fetch_rdata, 32'h2222_2222);

        // Data read with the bus stalled indefinitely
        bus.data_req        = 1'b1;
        bus.data_we         = 1'b0;
        bus.data_addr       = 32'h0000_0040;
        bus.mem_waitrequest = 1'b1;
        tick();
        chk("st_rd", 32'(bus.mem_read), 32'd1);
`ifdef MEM_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_rd",     32'(bus.mem_read), 32'd1);
            chk("to_nodone", 32'(bus.data_done), 32'd0);
            chk("to_noerr",  32'(bus.error), 32'd0);
        end
        tick();
        chk("to_rdoff", 32'(bus.mem_read), 32'd0);
        chk("to_done",  32'(bus.data_done), 32'd1);
        chk("to_drd",   bus.data_rdata, 32'h0);
        chk("to_err",   32'(bus.error), 32'd1);
        bus.data_req        = 1'b0;
        bus.mem_waitrequest = 1'b0;
        repeat (2) tick();
        chk("to_sticky", 32'(bus.error), 32'd1);
        chk("to_idle",   32'(bus.busy), 32'd0);
`else
        repeat (100) tick();
        chk("st_still_rd", 32'(bus.mem_read), 32'd1);
        chk("st_busy",     32'(bus.busy), 32'd1);
        chk("st_nodone",   32'(bus.data_done), 32'd0);
        chk("st_noerr",    32'(bus.error), 32'd0);
        chk("st_drd_hold", bus.data_rdata, 32'h3333_3333);
        bus.data_req = 1'b0;
`endif
        #2;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Reset asserted in the middle of a stalled fetch
        bus.fetch_req       = 1'b1;
        bus.fetch_addr      = 32'h0040_0008;
        bus.mem_waitrequest = 1'b1;
        tick();
        chk("ra_rd", 32'(bus.mem_read), 32'd1);
        tick();
        chk("ra_rd2", 32'(bus.mem_read), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ra_rdoff", 32'(bus.mem_read), 32'd0);
        chk("ra_busy",  32'(bus.busy), 32'd0);
        chk("ra_done",  32'(bus.fetch_done), 32'd0);
        chk("ra_err",   32'(bus.error), 32'd0);
        chk("ra_frd",   bus.fetch_rdata, 32'h0);
        chk("ra_drd",   bus.data_rdata, 32'h0);
        bus.fetch_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("ra_nodone", 32'(bus.fetch_done), 32'd0);

        // Fresh fetch after reset release
        bus.fetch_req       = 1'b1;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = 32'hCAFE_F00D;
        tick();
        chk("f2_rd",   32'(bus.mem_read), 32'd1);
        chk("f2_addr", bus.mem_address, 32'h0040_0008);
        tick();
        chk("f2_done",  32'(bus.fetch_done), 32'd1);
        chk("f2_rdata", bus.fetch_rdata, 32'hCAFE_F00D);
        bus.fetch_req = 1'b0;
        tick();
        chk("f2_idle", 32'(bus.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
